// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, instruction field positions and source-usage helpers.
package mips_defs;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  // Jumps carry a target in the rs field, not a register index.
  function automatic logic uses_rs(input logic [5:0] op);
    return !((op == OP_J) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
      OP_LW:                           return 1'b0;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding (EX over MEM) and load-use hazard detection.
module hazard_fwd_unit #(
  parameter int unsigned ADDR_SIZE  = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  valid_i,
  input  logic [5:0]            op_i,
  input  logic [ADDR_SIZE-1:0]  rs_i,
  input  logic [ADDR_SIZE-1:0]  rt_i,
  input  logic [DATA_WIDTH-1:0] rd1_i,
  input  logic [DATA_WIDTH-1:0] rd2_i,
  input  logic                  ex_we_i,
  input  logic [ADDR_SIZE-1:0]  ex_wa_i,
  input  logic                  ex_is_load_i,
  input  logic [DATA_WIDTH-1:0] ex_result_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_SIZE-1:0]  mem_wa_i,
  input  logic [DATA_WIDTH-1:0] mem_result_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  stall_o
);
  import mips_defs::*;

  logic use_rs, use_rt, ex_fwd_ok, hazard;

  assign use_rs    = valid_i && uses_rs(op_i);
  assign use_rt    = valid_i && uses_rt(op_i);
  // A load's EX result is an address, not data; it must never be forwarded.
  assign ex_fwd_ok = ex_we_i && !ex_is_load_i;

  always_comb begin
    a_o = rd1_i;
    if (rs_i == '0)                            a_o = '0;
    else if (ex_fwd_ok && (ex_wa_i == rs_i))   a_o = ex_result_i;
    else if (mem_we_i && (mem_wa_i == rs_i))   a_o = mem_result_i;

    b_o = rd2_i;
    if (rt_i == '0)                            b_o = '0;
    else if (ex_fwd_ok && (ex_wa_i == rt_i))   b_o = ex_result_i;
    else if (mem_we_i && (mem_wa_i == rt_i))   b_o = mem_result_i;
  end

  assign hazard  = ex_is_load_i && ex_we_i && (ex_wa_i != '0) &&
                   ((use_rs && (ex_wa_i == rs_i)) || (use_rt && (ex_wa_i == rt_i)));
  assign stall_o = hazard && !flush_i;

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage front end: IF/ID and ID/EX pipeline registers around operand resolution.
module id_operand_stage #(
  parameter int unsigned ADDR_SIZE  = 5,
  parameter int unsigned DATA_WIDTH = mips_defs::DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc4,
  input  logic                  flush,
  output logic                  stall_o,
  output logic [ADDR_SIZE-1:0]  ra1,
  output logic [ADDR_SIZE-1:0]  ra2,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic                  ex_we,
  input  logic [ADDR_SIZE-1:0]  ex_wa,
  input  logic                  ex_is_load,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  mem_we,
  input  logic [ADDR_SIZE-1:0]  mem_wa,
  input  logic [DATA_WIDTH-1:0] mem_result,
  output logic                  idex_valid,
  output logic [5:0]            idex_op,
  output logic [5:0]            idex_funct,
  output logic [4:0]            idex_shamt,
  output logic [ADDR_SIZE-1:0]  idex_rs,
  output logic [ADDR_SIZE-1:0]  idex_rt,
  output logic [ADDR_SIZE-1:0]  idex_rd,
  output logic [DATA_WIDTH-1:0] idex_a,
  output logic [DATA_WIDTH-1:0] idex_b,
  output logic [DATA_WIDTH-1:0] idex_imm,
  output logic [DATA_WIDTH-1:0] idex_pc4
);
  import mips_defs::*;

  typedef struct packed {
    logic                  valid;
    logic [5:0]            op;
    logic [5:0]            funct;
    logic [4:0]            shamt;
    logic [ADDR_SIZE-1:0]  rs;
    logic [ADDR_SIZE-1:0]  rt;
    logic [ADDR_SIZE-1:0]  rd;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc4;
  } idex_t;

  logic                  ifid_valid_q, ifid_valid_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  idex_t                 idex_q, idex_d;

  logic [5:0]            dec_op;
  logic [ADDR_SIZE-1:0]  dec_rs, dec_rt;
  logic [15:0]           dec_imm;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  assign dec_op  = ifid_instr_q[OP_MSB:OP_LSB];
  assign dec_rs  = ifid_instr_q[RS_MSB:RS_LSB];
  assign dec_rt  = ifid_instr_q[RT_MSB:RT_LSB];
  assign dec_imm = ifid_instr_q[IMM_MSB:IMM_LSB];
  assign ra1     = dec_rs;
  assign ra2     = dec_rt;

  hazard_fwd_unit #(
    .ADDR_SIZE  (ADDR_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hazard_fwd (
    .valid_i      (ifid_valid_q),
    .op_i         (dec_op),
    .rs_i         (dec_rs),
    .rt_i         (dec_rt),
    .rd1_i        (rd1),
    .rd2_i        (rd2),
    .ex_we_i      (ex_we),
    .ex_wa_i      (ex_wa),
    .ex_is_load_i (ex_is_load),
    .ex_result_i  (ex_result),
    .mem_we_i     (mem_we),
    .mem_wa_i     (mem_wa),
    .mem_result_i (mem_result),
    .flush_i      (flush),
    .a_o          (fwd_a),
    .b_o          (fwd_b),
    .stall_o      (stall_o)
  );

  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    idex_d       = idex_q;
    if (flush) begin
      // Valid bits alone mask the killed instructions.
      ifid_valid_d = 1'b0;
      idex_d.valid = 1'b0;
    end else if (stall_o) begin
      idex_d = '0;
    end else begin
      ifid_valid_d = if_valid;
      ifid_instr_d = if_instr;
      ifid_pc4_d   = if_pc4;
      idex_d.valid = ifid_valid_q;
      idex_d.op    = dec_op;
      idex_d.funct = ifid_instr_q[FUNCT_MSB:FUNCT_LSB];
      idex_d.shamt = ifid_instr_q[SHAMT_MSB:SHAMT_LSB];
      idex_d.rs    = dec_rs;
      idex_d.rt    = dec_rt;
      idex_d.rd    = ifid_instr_q[RD_MSB:RD_LSB];
      idex_d.a     = fwd_a;
      idex_d.b     = fwd_b;
      idex_d.imm   = {{(DATA_WIDTH-16){dec_imm[15]}}, dec_imm};
      idex_d.pc4   = ifid_pc4_q;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      idex_q       <= '0;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      idex_q       <= idex_d;
    end
  end

  assign idex_valid = idex_q.valid;
  assign idex_op    = idex_q.op;
  assign idex_funct = idex_q.funct;
  assign idex_shamt = idex_q.shamt;
  assign idex_rs    = idex_q.rs;
  assign idex_rt    = idex_q.rt;
  assign idex_rd    = idex_q.rd;
  assign idex_a     = idex_q.a;
  assign idex_b     = idex_q.b;
  assign idex_imm   = idex_q.imm;
  assign idex_pc4   = idex_q.pc4;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios then random traffic against a stage-level model.
module tb_id_operand_stage;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        if_valid, flush, stall_o;
  logic [31:0] if_instr, if_pc4, rd1, rd2;
  logic [4:0]  ra1, ra2;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_wa, mem_wa;
  logic [31:0] ex_result, mem_result;
  logic        idex_valid;
  logic [5:0]  idex_op, idex_funct;
  logic [4:0]  idex_shamt, idex_rs, idex_rt, idex_rd;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc4;

  logic [31:0] regfile [32];

  always #5 CLK = ~CLK;

  assign rd1 = regfile[ra1];
  assign rd2 = regfile[ra2];

  id_operand_stage #(.ADDR_SIZE(5), .DATA_WIDTH(32)) dut (
    .CLK        (CLK),        .rst_n      (rst_n),
    .if_valid   (if_valid),   .if_instr   (if_instr),   .if_pc4    (if_pc4),
    .flush      (flush),      .stall_o    (stall_o),
    .ra1        (ra1),        .ra2        (ra2),        .rd1       (rd1),     .rd2 (rd2),
    .ex_we      (ex_we),      .ex_wa      (ex_wa),      .ex_is_load(ex_is_load),
    .ex_result  (ex_result),  .mem_we     (mem_we),     .mem_wa    (mem_wa),
    .mem_result (mem_result), .idex_valid (idex_valid), .idex_op   (idex_op),
    .idex_funct (idex_funct), .idex_shamt (idex_shamt), .idex_rs   (idex_rs),
    .idex_rt    (idex_rt),    .idex_rd    (idex_rd),    .idex_a    (idex_a),
    .idex_b     (idex_b),     .idex_imm   (idex_imm),   .idex_pc4  (idex_pc4)
  );

  // Stage model: what IF/ID holds and what ID/EX is expected to show.
  logic        m_ifv, m_known;
  logic [31:0] m_instr, m_pc4;
  logic        e_valid, e_known;
  logic [5:0]  e_op, e_funct;
  logic [4:0]  e_shamt, e_rs, e_rt, e_rd;
  logic [31:0] e_a, e_b, e_imm, e_pc4;
  logic        last_stall;
  int          n_pass = 0;
  int          n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic src_rs(input logic [5:0] op);
    return !(op == 6'h02 || op == 6'h03);
  endfunction

  function automatic logic src_rt(input logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (ex_we && ex_wa == r && !ex_is_load) return ex_result;
    if (mem_we && mem_wa == r) return mem_result;
    return regfile[r];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h08};
    logic [15:0] low;
    low = 16'($urandom);
    return {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
  endfunction

  task automatic model_reset();
    m_ifv = 1'b0; m_known = 1'b1; m_instr = '0; m_pc4 = '0;
    e_valid = 1'b0; e_known = 1'b1; e_op = '0; e_funct = '0; e_shamt = '0;
    e_rs = '0; e_rt = '0; e_rd = '0; e_a = '0; e_b = '0; e_imm = '0; e_pc4 = '0;
  endtask

  task automatic set_idle();
    if_valid = 1'b0; if_instr = '0; if_pc4 = '0; flush = 1'b0;
    ex_we = 1'b0; ex_wa = '0; ex_is_load = 1'b0; ex_result = '0;
    mem_we = 1'b0; mem_wa = '0; mem_result = '0;
  endtask

  task automatic check_idex();
    chk("idex_valid", 32'(idex_valid), 32'(e_valid));
    if (e_known) begin
      chk("idex_op", 32'(idex_op), 32'(e_op));
      chk("idex_funct", 32'(idex_funct), 32'(e_funct));
      chk("idex_shamt", 32'(idex_shamt), 32'(e_shamt));
      chk("idex_rs", 32'(idex_rs), 32'(e_rs));
      chk("idex_rt", 32'(idex_rt), 32'(e_rt));
      chk("idex_rd", 32'(idex_rd), 32'(e_rd));
      chk("idex_a", idex_a, e_a);
      chk("idex_b", idex_b, e_b);
      chk("idex_imm", idex_imm, e_imm);
      chk("idex_pc4", idex_pc4, e_pc4);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check ID/EX after the edge.
  task automatic step();
    logic       h;
    logic [5:0] op;
    logic [4:0] rs, rt;
    #1;
    op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
    h = m_ifv && ex_is_load && ex_we && ex_wa != 5'd0 &&
        ((src_rs(op) && ex_wa == rs) || (src_rt(op) && ex_wa == rt));
    last_stall = stall_o;
    chk("stall_o", 32'(stall_o), 32'(h && !flush));
    if (m_known) begin
      chk("ra1", 32'(ra1), 32'(rs));
      chk("ra2", 32'(ra2), 32'(rt));
    end
    if (flush) begin
      m_ifv = 1'b0; m_known = 1'b0; e_valid = 1'b0; e_known = 1'b0;
    end else if (h) begin
      e_valid = 1'b0; e_known = 1'b1; e_op = '0; e_funct = '0; e_shamt = '0;
      e_rs = '0; e_rt = '0; e_rd = '0; e_a = '0; e_b = '0; e_imm = '0; e_pc4 = '0;
    end else begin
      e_valid = m_ifv; e_known = m_known;
      e_op = op; e_rs = rs; e_rt = rt; e_rd = m_instr[15:11];
      e_shamt = m_instr[10:6]; e_funct = m_instr[5:0];
      e_imm = {{16{m_instr[15]}}, m_instr[15:0]};
      e_a = operand(rs); e_b = operand(rt); e_pc4 = m_pc4;
      m_ifv = if_valid; m_instr = if_instr; m_pc4 = if_pc4; m_known = 1'b1;
    end
    @(posedge CLK);
    #1;
    check_idex();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[0] = 32'hDEAD_BEEF;
    set_idle();
    if_valid = 1'b1; if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    rst_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    chk("reset_stall", 32'(stall_o), 32'd0);
    check_idex();
    @(negedge CLK);
    rst_n = 1'b1;

    // EX forward: sub $4,$3,$0 reads $3 from EX
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd3, 5'd0, 5'd4, 6'h22); step();
    set_idle(); ex_we = 1'b1; ex_wa = 5'd3; ex_result = 32'h55; step();
    chk("ex_fwd_a", idex_a, 32'h55);

    // EX beats MEM, then $0 always reads zero
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd5, 5'd5, 5'd7, 6'h20); step();
    set_idle(); ex_we = 1'b1; ex_wa = 5'd5; ex_result = 32'h11;
    mem_we = 1'b1; mem_wa = 5'd5; mem_result = 32'h22;
    if_valid = 1'b1; if_instr = rtype(5'd0, 5'd0, 5'd8, 6'h20); step();
    chk("ex_over_mem", idex_a, 32'h11);
    set_idle(); ex_we = 1'b1; ex_wa = 5'd0; ex_result = 32'h99;
    mem_we = 1'b1; mem_wa = 5'd0; mem_result = 32'h77; step();
    chk("r0_zero", idex_a, 32'h0);

    // Load-use: one stall, bubble, then MEM supplies the load data
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd2, 5'd2, 5'd6, 6'h20); step();
    set_idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd2;
    if_valid = 1'b1; if_instr = rtype(5'd1, 5'd1, 5'd9, 6'h20); step();
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_bubble", 32'(idex_valid), 32'd0);
    set_idle(); mem_we = 1'b1; mem_wa = 5'd2; mem_result = 32'hABCD; step();
    chk("lu_valid", 32'(idex_valid), 32'd1);
    chk("lu_a", idex_a, 32'hABCD);
    chk("lu_b", idex_b, 32'hABCD);

    // Flush overrides stall and kills both stages
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd2, 5'd2, 5'd6, 6'h20); step();
    set_idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd2; flush = 1'b1;
    if_valid = 1'b1; if_instr = rtype(5'd1, 5'd1, 5'd9, 6'h20); step();
    chk("fl_stall", 32'(last_stall), 32'd0);
    chk("fl_idex", 32'(idex_valid), 32'd0);
    set_idle(); step();
    chk("fl_ifid", 32'(idex_valid), 32'd0);

    // Jump with rs field matching the load destination must not stall
    set_idle(); if_valid = 1'b1; if_instr = {6'h02, 5'd2, 21'h0}; step();
    set_idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd2; step();
    chk("j_nostall", 32'(last_stall), 32'd0);
    chk("j_valid", 32'(idex_valid), 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) regfile[$urandom_range(1, 31)] = $urandom;
      if_valid = $urandom_range(0, 3) != 0; if_instr = rand_instr(); if_pc4 = $urandom;
      flush = $urandom_range(0, 9) == 0;
      ex_we = 1'($urandom_range(0, 1)); ex_wa = 5'($urandom_range(0, 7));
      ex_is_load = $urandom_range(0, 2) == 0; ex_result = $urandom;
      mem_we = 1'($urandom_range(0, 1)); mem_wa = 5'($urandom_range(0, 7));
      mem_result = $urandom;
      step();
    end

    // Reset asserted while a load-use stall is pending
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd2, 5'd2, 5'd6, 6'h20); step();
    set_idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd2; #1;
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    model_reset();
    check_idex();
    @(negedge CLK);
    rst_n = 1'b1;
    set_idle(); if_valid = 1'b1; if_instr = rtype(5'd1, 5'd3, 5'd10, 6'h20);
    if_pc4 = 32'h1000; step();
    chk("rel_cyc1", 32'(idex_valid), 32'd0);
    set_idle(); step();
    chk("rel_cyc2", 32'(idex_valid), 32'd1);
    chk("rel_pc4", idex_pc4, 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-stage front end of the pipelined MIPS CPU; sits between the fetch stage and the execute stage, wrapped around the register file.
- Owns the IF/ID pipeline register and drives the register-file read addresses RA1/RA2 from it.
- Resolves operands with EX/MEM forwarding and detects load-use hazards, stalling fetch and inserting bubbles.
- Flushes on branch/jump redirect and owns the ID/EX pipeline register.

Parameters:
- ADDR_SIZE, 5, register index width; must match the register file.
- DATA_WIDTH, 32, datapath and instruction width.

Ports:
- CLK  in  1  pipeline clock; all registers update on posedge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instr  in  DATA_WIDTH  fetched instruction.
- if_pc4  in  DATA_WIDTH  PC+4 of the fetched instruction.
- flush  in  1  branch/jump redirect from EX; kills younger instructions.
- stall_o  out  1  hold PC and fetch output this cycle (combinational).
- ra1  out  ADDR_SIZE  register-file read address 1 = IF/ID rs.
- ra2  out  ADDR_SIZE  register-file read address 2 = IF/ID rt.
- rd1  in  DATA_WIDTH  register-file read data 1.
- rd2  in  DATA_WIDTH  register-file read data 2.
- ex_we  in  1  instruction now in EX writes a register.
- ex_wa  in  ADDR_SIZE  destination register of that EX instruction.
- ex_is_load  in  1  EX instruction is a load (lw).
- ex_result  in  DATA_WIDTH  EX ALU result.
- mem_we  in  1  instruction now in MEM writes a register.
- mem_wa  in  ADDR_SIZE  destination register of that MEM instruction.
- mem_result  in  DATA_WIDTH  MEM-stage writeback value.
- idex_valid  out  1  ID/EX holds a real instruction.
- idex_op  out  6  opcode.
- idex_funct  out  6  funct field.
- idex_shamt  out  5  shift amount.
- idex_rs  out  ADDR_SIZE  rs index.
- idex_rt  out  ADDR_SIZE  rt index.
- idex_rd  out  ADDR_SIZE  rd index.
- idex_a  out  DATA_WIDTH  resolved rs operand.
- idex_b  out  DATA_WIDTH  resolved rt operand.
- idex_imm  out  DATA_WIDTH  sign-extended imm16.
- idex_pc4  out  DATA_WIDTH  PC+4.

Behaviour:
- Reset (asynchronous, active-low): IF/ID valid=0 and instr=0; every idex_* output=0. stall_o is combinational and reads 0 while reset is held.
- Register-file writes land on negedge, so a WB-stage write in cycle N is readable in ID in cycle N. No WB forwarding path.
- Source usage:
  - use_rs=1 unless op is 0x02 or 0x03.
  - use_rt=1 for op 0x00, 0x04, 0x05, 0x2B.
  - Both are 0 when IF/ID valid=0.
- Forwarding, per operand with index r:
  - If r==0, the value is 0.
  - Else if ex_we and ex_wa==r and !ex_is_load, use ex_result.
  - Else if mem_we and mem_wa==r, use mem_result.
  - Else use rd1/rd2.
  - EX takes priority over MEM.
- Load-use: hazard = ex_is_load && ex_we && ex_wa!=0 && ((use_rs && ex_wa==rs) || (use_rt && ex_wa==rt)). stall_o = hazard && !flush.
- Per-cycle priority at posedge:
  - flush: IF/ID valid←0 and ID/EX valid←0. Field registers may retain values, but valid=0 masks them.
  - else stall_o: IF/ID holds; ID/EX loads a bubble (valid=0, all fields 0). Latency +1 cycle. The next cycle's MEM forwarding supplies the load data.
  - else: IF/ID←{if_valid, if_instr, if_pc4}; ID/EX←decoded and resolved IF/ID contents, with valid = IF/ID valid.
- Latency: 1 cycle IF→ID and 1 cycle ID→EX.
- Back-to-back loads into the same register: only the youngest in EX is checked, so at most one stall per dependence.
- Bubbles (valid=0) must never assert write-enable downstream; downstream gates on idex_valid.
- Reset asserted mid-stall: clears all state immediately; stall_o drops because IF/ID valid=0.

Decomposition:
- Shared package (mips_defs): opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW; instruction field bit-ranges; DATA_WIDTH.
- Sub-module hazard_fwd_unit (combinational): computes use_rs/use_rt, both forward muxes and hazard/stall_o. Instantiated once.

Test Plan:
- Reset: hold rst_n=0 mid-stream with if_valid=1 -> idex_valid=0, all idex_*=0, stall_o=0; first valid instruction reaches idex 2 cycles after release.
- EX forward: add $3,$1,$2 in EX (ex_we=1, ex_wa=3, ex_result=0x55), ID holds sub $4,$3,$0 -> idex_a=0x55 next cycle, rd1 ignored.
- EX over MEM: ex_wa=mem_wa=5, ex_result=0x11, mem_result=0x22, ID reads $5 -> idex_a=0x11; register $0 with ex_wa=0 -> idex_a=0.
- Load-use: lw $2 in EX, add $6,$2,$2 in ID -> stall_o=1 one cycle, IF/ID held, bubble (idex_valid=0); next cycle MEM forward gives idex_a=idex_b=mem_result.
- Flush with stall: load-use condition plus flush=1 -> stall_o=0; IF/ID and ID/EX both valid=0 next cycle.
- No false stall: lw $2 in EX, j target in ID (op 0x02, rs field=2) -> stall_o=0.
